// File: rtl/uart_rx_async.sv
// ============================================================================
// uart_rx_async : 16x-oversampled UART receiver with parity/stop checking
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_async #(
    parameter int RX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_parity,
    input  logic       clear_framing,
    input  logic       fifo_full,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       fifo_write_rx
);

    localparam logic c_use_fifo = (RX_FIFO != 0);

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        START_CHECK = 3'd1,
        DATA_BITS   = 3'd2,
        PARITY_BIT  = 3'd3,
        STOP_BIT    = 3'd4
    } rx_state_t;

    rx_state_t  r_state;
    logic       r_rx_meta;
    logic       r_rx_sync;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic       r_par;
    logic [7:0] r_rx_byte;
    logic       r_rx_ready;
    logic       r_parity_err;
    logic       r_framing_err;
    logic       r_overflow;
    logic       r_fifo_wr_n;

    logic w_mid;
    logic w_last_bit;

    assign w_mid      = (r_cnt == 4'd15);
    assign w_last_bit = bit8 ? (r_idx == 3'd7) : (r_idx == 3'd6);

    // Synchronizer resets to the idle line level so reset never fakes a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RX_IDLE;
            r_cnt         <= 4'd0;
            r_idx         <= 3'd0;
            r_shift       <= 8'h00;
            r_par         <= 1'b0;
            r_rx_byte     <= 8'h00;
            r_rx_ready    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
            r_fifo_wr_n   <= 1'b1;
        end else begin
            r_fifo_wr_n <= 1'b1;
            // Clears come first so a same-cycle set below takes precedence
            if (clear_parity)  r_parity_err  <= 1'b0;
            if (clear_framing) r_framing_err <= 1'b0;
            if (read_rx_byte) begin
                r_rx_ready <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (baud_clock) begin
                r_cnt <= r_cnt + 4'd1;
                case (r_state)
                    RX_IDLE: begin
                        if (!r_rx_sync) begin
                            r_cnt   <= 4'd0;
                            r_state <= START_CHECK;
                        end
                    end
                    START_CHECK: begin
                        if (r_cnt == 4'd7) begin
                            if (r_rx_sync) begin
                                r_state <= RX_IDLE;
                            end else begin
                                r_cnt   <= 4'd0;
                                r_idx   <= 3'd0;
                                r_par   <= 1'b0;
                                r_state <= DATA_BITS;
                            end
                        end
                    end
                    DATA_BITS: begin
                        if (w_mid) begin
                            r_shift[r_idx] <= r_rx_sync;
                            r_par          <= r_par ^ r_rx_sync;
                            if (w_last_bit)
                                r_state <= parity_en ? PARITY_BIT : STOP_BIT;
                            else
                                r_idx <= r_idx + 3'd1;
                        end
                    end
                    PARITY_BIT: begin
                        if (w_mid) begin
                            if (r_rx_sync != (odd_n_even ^ r_par))
                                r_parity_err <= 1'b1;
                            r_state <= STOP_BIT;
                        end
                    end
                    STOP_BIT: begin
                        if (w_mid) begin
                            if (!r_rx_sync)
                                r_framing_err <= 1'b1;
                            r_rx_byte <= {bit8 & r_shift[7], r_shift[6:0]};
                            if (c_use_fifo) begin
                                if (fifo_full)
                                    r_overflow <= 1'b1;
                                else
                                    r_fifo_wr_n <= 1'b0;
                            end else begin
                                // A load wins over a same-cycle read of the old byte
                                r_rx_ready <= 1'b1;
                                if (r_rx_ready && !read_rx_byte)
                                    r_overflow <= 1'b1;
                            end
                            r_state <= RX_IDLE;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_byte       = r_rx_byte;
    assign rx_ready      = r_rx_ready;
    assign parity_err    = r_parity_err;
    assign framing_err   = r_framing_err;
    assign overflow      = r_overflow;
    assign fifo_write_rx = r_fifo_wr_n;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_async.sv
// ============================================================================
// tb_uart_rx_async : directed bench for uart_rx_async (holding-reg and FIFO modes)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_async;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_clock = 1'b0;
    logic rx = 1'b1;
    logic bit8 = 1'b1;
    logic parity_en = 1'b0;
    logic odd_n_even = 1'b0;
    logic read_rx_byte = 1'b0;
    logic clear_parity = 1'b0;
    logic clear_framing = 1'b0;
    logic fifo_full = 1'b0;
    logic no_full = 1'b0;

    logic [7:0] rx_byte, rx_byte_f;
    logic       rx_ready, rx_ready_f;
    logic       parity_err, parity_err_f;
    logic       framing_err, framing_err_f;
    logic       overflow, overflow_f;
    logic       fifo_write_rx, fifo_write_rx_f;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    int strobe_cnt = 0;
    logic [7:0] strobe_byte = 8'h00;

    uart_rx_async #(.RX_FIFO(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
        .clear_framing(clear_framing), .fifo_full(no_full),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .parity_err(parity_err),
        .framing_err(framing_err), .overflow(overflow), .fifo_write_rx(fifo_write_rx)
    );

    uart_rx_async #(.RX_FIFO(1)) u_dut_fifo (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
        .clear_framing(clear_framing), .fifo_full(fifo_full),
        .rx_byte(rx_byte_f), .rx_ready(rx_ready_f), .parity_err(parity_err_f),
        .framing_err(framing_err_f), .overflow(overflow_f), .fifo_write_rx(fifo_write_rx_f)
    );

    always #5 clk = ~clk;

    // One baud tick every 4 clk, so one bit time is 64 clk
    always @(negedge clk) begin
        baud_clock = (phase == 3);
        phase = (phase + 1) % 4;
    end

    always @(negedge clk) begin
        if (!fifo_write_rx_f) begin
            strobe_cnt  = strobe_cnt + 1;
            strobe_byte = rx_byte_f;
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!baud_clock);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start edge is placed just after a baud tick, which puts the stop-bit
    // load on the 36th posedge after the stop bit is driven.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                              input bit par_val, input bit stop_val, input bit read_at_load);
        wait_tick();
        @(negedge clk);
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            hold(64);
        end
        if (has_par) begin
            rx = par_val;
            hold(64);
        end
        rx = stop_val;
        hold(35);
        if (read_at_load) read_rx_byte = 1'b1;
        hold(1);
        read_rx_byte = 1'b0;
        hold(28);
        rx = 1'b1;
        hold(64);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
    endtask

    initial begin
        hold(4);
        check_eq("reset_rx_byte", rx_byte, 8'h00);
        check_eq("reset_rx_ready", {7'd0, rx_ready}, 8'd0);
        check_eq("reset_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
        check_eq("reset_fifo_wr", {7'd0, fifo_write_rx_f}, 8'd1);
        reset_n = 1'b1;
        hold(70);

        // 8N1 0xA5
        strobe_cnt = 0;
        send_frame(8'hA5, 8, 0, 0, 1, 0);
        check_eq("8n1_byte", rx_byte, 8'hA5);
        check_eq("8n1_ready", {7'd0, rx_ready}, 8'd1);
        check_eq("8n1_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
        check_eq("8n1_fifo_strobes", strobe_cnt[7:0], 8'd1);
        check_eq("8n1_fifo_byte", strobe_byte, 8'hA5);
        check_eq("8n1_fifo_ready", {7'd0, rx_ready_f}, 8'd0);
        pulse_read();
        hold(1);
        check_eq("8n1_read_clears", {7'd0, rx_ready}, 8'd0);

        // 8O1 parity
        parity_en = 1'b1;
        odd_n_even = 1'b1;
        send_frame(8'h03, 8, 1, 1, 1, 0);
        check_eq("8o1_good_perr", {7'd0, parity_err}, 8'd0);
        check_eq("8o1_good_byte", rx_byte, 8'h03);
        pulse_read();
        send_frame(8'h03, 8, 1, 0, 1, 0);
        check_eq("8o1_bad_perr", {7'd0, parity_err}, 8'd1);
        check_eq("8o1_bad_byte", rx_byte, 8'h03);
        check_eq("8o1_bad_ready", {7'd0, rx_ready}, 8'd1);
        pulse_read();
        @(negedge clk) clear_parity = 1'b1;
        @(negedge clk) clear_parity = 1'b0;
        check_eq("clear_parity", {7'd0, parity_err}, 8'd0);

        // 7E1
        bit8 = 1'b0;
        odd_n_even = 1'b0;
        send_frame(8'h7F, 7, 1, 1, 1, 0);
        check_eq("7e1_byte", rx_byte, 8'h7F);
        check_eq("7e1_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
        pulse_read();
        send_frame(8'h55, 7, 1, 0, 0, 0);
        check_eq("7e1_framing", {7'd0, framing_err}, 8'd1);
        check_eq("7e1_fram_byte", rx_byte, 8'h55);
        check_eq("7e1_fram_perr", {7'd0, parity_err}, 8'd0);
        pulse_read();
        @(negedge clk) clear_framing = 1'b1;
        @(negedge clk) clear_framing = 1'b0;
        check_eq("clear_framing", {7'd0, framing_err}, 8'd0);

        // Glitch rejection, back to 8N1
        bit8 = 1'b1;
        parity_en = 1'b0;
        hold(128);
        wait_tick();
        @(negedge clk) rx = 1'b0;
        hold(16);
        rx = 1'b1;
        hold(192);
        check_eq("glitch_ready", {7'd0, rx_ready}, 8'd0);
        check_eq("glitch_flags", {5'd0, parity_err, framing_err, overflow}, 8'd0);
        send_frame(8'h3C, 8, 0, 0, 1, 0);
        check_eq("after_glitch_byte", rx_byte, 8'h3C);
        check_eq("after_glitch_ready", {7'd0, rx_ready}, 8'd1);
        pulse_read();

        // Overflow and load-vs-read precedence
        send_frame(8'h11, 8, 0, 0, 1, 0);
        send_frame(8'h22, 8, 0, 0, 1, 0);
        check_eq("ovf_byte", rx_byte, 8'h22);
        check_eq("ovf_flag", {7'd0, overflow}, 8'd1);
        pulse_read();
        hold(1);
        check_eq("ovf_read_clears", {6'd0, rx_ready, overflow}, 8'd0);
        send_frame(8'h11, 8, 0, 0, 1, 0);
        send_frame(8'h22, 8, 0, 0, 1, 1);
        check_eq("coinc_read_ovf", {7'd0, overflow}, 8'd0);
        check_eq("coinc_read_ready", {7'd0, rx_ready}, 8'd1);
        check_eq("coinc_read_byte", rx_byte, 8'h22);
        pulse_read();

        // FIFO mode
        strobe_cnt = 0;
        send_frame(8'h5A, 8, 0, 0, 1, 0);
        check_eq("fifo_strobes", strobe_cnt[7:0], 8'd1);
        check_eq("fifo_byte", strobe_byte, 8'h5A);
        check_eq("fifo_ready_low", {7'd0, rx_ready_f}, 8'd0);
        check_eq("fifo_no_ovf", {7'd0, overflow_f}, 8'd0);
        fifo_full = 1'b1;
        strobe_cnt = 0;
        send_frame(8'hC3, 8, 0, 0, 1, 0);
        check_eq("fifo_full_strobes", strobe_cnt[7:0], 8'd0);
        check_eq("fifo_full_ovf", {7'd0, overflow_f}, 8'd1);
        check_eq("fifo_full_byte", rx_byte_f, 8'hC3);
        fifo_full = 1'b0;

        // Reset in the middle of data bits
        wait_tick();
        @(negedge clk) rx = 1'b0;
        hold(64);
        rx = 1'b1;
        hold(64);
        rx = 1'b0;
        hold(20);
        reset_n = 1'b0;
        hold(3);
        check_eq("rst_mid_byte", rx_byte, 8'h00);
        check_eq("rst_mid_byte_f", rx_byte_f, 8'h00);
        check_eq("rst_mid_flags", {4'd0, rx_ready, parity_err, framing_err, overflow}, 8'd0);
        check_eq("rst_mid_flags_f", {5'd0, parity_err_f, framing_err_f, overflow_f}, 8'd0);
        check_eq("rst_mid_fifo_wr", {7'd0, fifo_write_rx_f}, 8'd1);
        rx = 1'b1;
        hold(2);
        reset_n = 1'b1;
        hold(128);
        strobe_cnt = 0;
        send_frame(8'h96, 8, 0, 0, 1, 0);
        check_eq("post_rst_byte", rx_byte, 8'h96);
        check_eq("post_rst_ready", {7'd0, rx_ready}, 8'd1);
        check_eq("post_rst_strobes", strobe_cnt[7:0], 8'd1);
        check_eq("post_rst_fifo_byte", strobe_byte, 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
